// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared AXI read-channel encodings for the read responder:
//   burst_e    - AR burst type (FIXED / INCR / WRAP / reserved)
//   resp_e     - R response code
//   rd_state_e - responder FSM states
//   LFSR_SEED  - reset value of the optional stall LFSR
//   wrap_len_ok() - legal WRAP burst lengths (2, 4, 8 or 16 beats)
// ---------------------------------------------------------------------------
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } resp_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } rd_state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // arlen is beats minus one, so legal WRAP lengths are 1, 3, 7, 15.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_rd_stall_lfsr.sv
// ---------------------------------------------------------------------------
// axi_rd_stall_lfsr
// 16-bit Fibonacci LFSR (x^16 + x^14 + x^13 + x^11 + 1) that advances every
// clock and reloads the seed while rst is low. Its bit0 requests a one-cycle
// bubble before the responder presents a new R beat.
// Ports:
//   clk   in   clock
//   rst   in   synchronous reset, active-low
//   stall out  current LFSR bit0
// ---------------------------------------------------------------------------
module axi_rd_stall_lfsr
    import axi_pkg::*;
(
    input  logic clk,
    input  logic rst,
    output logic stall
);

    logic [15:0] lfsr_reg;
    logic [15:0] lfsr_next;
    logic        feedback;

    // Right-shifting form: taps 16,14,13,11 map to bits 0,2,3,5.
    assign feedback  = lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5];
    assign lfsr_next = {feedback, lfsr_reg[15:1]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    assign stall = lfsr_reg[0];

endmodule

// File: rtl/axi_rd_responder.sv
// ---------------------------------------------------------------------------
// axi_rd_responder
// AXI4 read-only slave backed by an inferred block RAM of MEM_DEPTH words.
// One AR is accepted at a time (arready only in IDLE); the burst is then
// streamed on R with FIXED / INCR / WRAP address sequencing. Beats whose word
// index falls outside the memory, and whole bursts with an illegal size,
// illegal WRAP length or reserved burst type, return SLVERR with zero data.
// A backdoor port (ld_*) writes words at any time.
//
// Optional feature: define AXI_RD_STALL_EN to insert LFSR-driven one-cycle
// bubbles before new beats (instantiates axi_rd_stall_lfsr).
//
// Ports:
//   clk, rst (sync, active-low)
//   AR: axi_arready out; axi_arid/araddr/arlen/arsize/arburst/arvalid in;
//       axi_arlock/arcache/arprot in (ignored)
//   R : axi_rid/rresp/rvalid/rdata/rlast out; axi_rready in
//   ld_en/ld_addr/ld_data in: backdoor word write
// ---------------------------------------------------------------------------
module axi_rd_responder
    import axi_pkg::*;
#(
    parameter int ID_W      = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         axi_arready,
    input  logic [ID_W-1:0]              axi_arid,
    input  logic [ADDR_W-1:0]            axi_araddr,
    input  logic [7:0]                   axi_arlen,
    input  logic [2:0]                   axi_arsize,
    input  logic [1:0]                   axi_arburst,
    input  logic                         axi_arlock,
    input  logic [3:0]                   axi_arcache,
    input  logic [2:0]                   axi_arprot,
    input  logic                         axi_arvalid,
    output logic [ID_W-1:0]              axi_rid,
    output logic [1:0]                   axi_rresp,
    output logic                         axi_rvalid,
    output logic [DATA_W-1:0]            axi_rdata,
    output logic                         axi_rlast,
    input  logic                         axi_rready,
    input  logic                         ld_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] ld_addr,
    input  logic [DATA_W-1:0]            ld_data
);

    localparam int BYTE_SH = $clog2(DATA_W / 8);
    localparam int IDX_W   = $clog2(MEM_DEPTH);

    // Protection/cache/lock attributes carry no meaning for this memory.
    logic unused_attr;
    assign unused_attr = ^{axi_arlock, axi_arcache, axi_arprot};

    rd_state_e         state_reg,   state_next;
    logic              arready_reg, arready_next;
    logic              rvalid_reg,  rvalid_next;
    logic              rlast_reg,   rlast_next;
    resp_e             rresp_reg,   rresp_next;
    logic [ID_W-1:0]   id_reg,      id_next;
    logic [ADDR_W-1:0] addr_reg,    addr_next;
    logic [7:0]        len_reg,     len_next;
    logic [2:0]        size_reg,    size_next;
    burst_e            burst_reg,   burst_next;
    logic              err_all_reg, err_all_next;
    logic [7:0]        beat_reg,    beat_next;
    logic              pend_reg,    pend_next;

    logic [DATA_W-1:0] mem [0:MEM_DEPTH-1];
    logic [DATA_W-1:0] rd_word_reg;

    logic              ar_hs;
    logic              r_hs;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] rd_idx_full;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_in_range;
    logic              req_err;
    logic              stall;

    // Address of the beat after 'a'. WRAP keeps the bits above the wrap
    // window and lets the low bits roll over inside it.
    function automatic logic [ADDR_W-1:0] next_beat_addr(
        input logic [ADDR_W-1:0] a,
        input logic [2:0]        sz,
        input logic [7:0]        ln,
        input burst_e            bt
    );
        logic [ADDR_W-1:0] step;
        logic [ADDR_W-1:0] wrap_mask;
        logic [ADDR_W-1:0] inc;
        step      = ADDR_W'(1) << sz;
        wrap_mask = ((ADDR_W'(ln) + ADDR_W'(1)) << sz) - ADDR_W'(1);
        inc       = a + step;
        case (bt)
            BURST_FIXED: return a;
            BURST_WRAP:  return (a & ~wrap_mask) | (inc & wrap_mask);
            default:     return inc;
        endcase
    endfunction

`ifdef AXI_RD_STALL_EN
    axi_rd_stall_lfsr u_stall_lfsr (
        .clk   (clk),
        .rst   (rst),
        .stall (stall)
    );
`else
    assign stall = 1'b0;
`endif

    assign ar_hs = arready_reg & axi_arvalid;
    assign r_hs  = rvalid_reg & axi_rready;

    // In IDLE the first beat is fetched straight from araddr during the
    // handshake cycle so its data is ready one cycle later.
    assign rd_addr     = (state_reg == ST_IDLE) ? axi_araddr
                       : next_beat_addr(addr_reg, size_reg, len_reg, burst_reg);
    assign rd_idx_full = rd_addr >> BYTE_SH;
    assign rd_idx      = rd_idx_full[IDX_W-1:0];
    assign rd_in_range = rd_idx_full < ADDR_W'(MEM_DEPTH);

    assign req_err = (axi_arsize > 3'(BYTE_SH))
                   || (axi_arburst == BURST_RSVD)
                   || ((axi_arburst == BURST_WRAP) && !wrap_len_ok(axi_arlen));

    always_comb begin
        state_next   = state_reg;
        rvalid_next  = rvalid_reg;
        rlast_next   = rlast_reg;
        rresp_next   = rresp_reg;
        id_next      = id_reg;
        addr_next    = addr_reg;
        len_next     = len_reg;
        size_next    = size_reg;
        burst_next   = burst_reg;
        err_all_next = err_all_reg;
        beat_next    = beat_reg;
        pend_next    = pend_reg;
        rd_en        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (ar_hs) begin
                    state_next   = ST_BURST;
                    id_next      = axi_arid;
                    addr_next    = axi_araddr;
                    len_next     = axi_arlen;
                    size_next    = axi_arsize;
                    burst_next   = burst_e'(axi_arburst);
                    err_all_next = req_err;
                    beat_next    = 8'd0;
                    rd_en        = 1'b1;
                    rvalid_next  = !stall;
                    pend_next    = stall;
                    rlast_next   = (axi_arlen == 8'd0);
                    rresp_next   = (req_err || !rd_in_range) ? RESP_SLVERR : RESP_OKAY;
                end
            end
            ST_BURST: begin
                if (pend_reg) begin
                    // Bubble over: the fetched beat is already in rd_word_reg.
                    rvalid_next = 1'b1;
                    pend_next   = 1'b0;
                end else if (r_hs) begin
                    if (rlast_reg) begin
                        state_next  = ST_IDLE;
                        rvalid_next = 1'b0;
                        rlast_next  = 1'b0;
                    end else begin
                        rd_en       = 1'b1;
                        addr_next   = rd_addr;
                        beat_next   = beat_reg + 8'd1;
                        rvalid_next = !stall;
                        pend_next   = stall;
                        rlast_next  = ((beat_reg + 8'd1) == len_reg);
                        rresp_next  = (err_all_reg || !rd_in_range) ? RESP_SLVERR : RESP_OKAY;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        arready_next = (state_next == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rlast_reg   <= 1'b0;
            rresp_reg   <= RESP_OKAY;
            id_reg      <= '0;
            addr_reg    <= '0;
            len_reg     <= '0;
            size_reg    <= '0;
            burst_reg   <= BURST_FIXED;
            err_all_reg <= 1'b0;
            beat_reg    <= '0;
            pend_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            arready_reg <= arready_next;
            rvalid_reg  <= rvalid_next;
            rlast_reg   <= rlast_next;
            rresp_reg   <= rresp_next;
            id_reg      <= id_next;
            addr_reg    <= addr_next;
            len_reg     <= len_next;
            size_reg    <= size_next;
            burst_reg   <= burst_next;
            err_all_reg <= err_all_next;
            beat_reg    <= beat_next;
            pend_reg    <= pend_next;
        end
    end

    // Block RAM: contents survive reset. Read is registered and only
    // refreshed when a new beat is fetched, which holds rdata under
    // back-pressure; a same-cycle backdoor write yields the old word.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
        if (rd_en) begin
            rd_word_reg <= mem[rd_idx];
        end
    end

    assign axi_arready = arready_reg;
    assign axi_rvalid  = rvalid_reg;
    assign axi_rlast   = rlast_reg & rvalid_reg;
    assign axi_rresp   = rresp_reg;
    assign axi_rid     = id_reg;
    assign axi_rdata   = (rvalid_reg && (rresp_reg == RESP_OKAY)) ? rd_word_reg : '0;

endmodule

// File: tb/tb_axi_rd_responder.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_responder
// Directed and randomized read bursts against axi_rd_responder, compared with
// a reference model that computes every beat's address, data and response
// directly from the burst parameters and a shadow copy of the memory.
// ---------------------------------------------------------------------------
module tb_axi_rd_responder;

    localparam int ID_W      = 4;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MEM_DEPTH = 1024;

    logic              clk;
    logic              rst;
    logic              axi_arready;
    logic [ID_W-1:0]   axi_arid;
    logic [ADDR_W-1:0] axi_araddr;
    logic [7:0]        axi_arlen;
    logic [2:0]        axi_arsize;
    logic [1:0]        axi_arburst;
    logic              axi_arlock;
    logic [3:0]        axi_arcache;
    logic [2:0]        axi_arprot;
    logic              axi_arvalid;
    logic [ID_W-1:0]   axi_rid;
    logic [1:0]        axi_rresp;
    logic              axi_rvalid;
    logic [DATA_W-1:0] axi_rdata;
    logic              axi_rlast;
    logic              axi_rready;
    logic              ld_en;
    logic [9:0]        ld_addr;
    logic [DATA_W-1:0] ld_data;

    axi_rd_responder #(
        .ID_W      (ID_W),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .axi_arready (axi_arready),
        .axi_arid    (axi_arid),
        .axi_araddr  (axi_araddr),
        .axi_arlen   (axi_arlen),
        .axi_arsize  (axi_arsize),
        .axi_arburst (axi_arburst),
        .axi_arlock  (axi_arlock),
        .axi_arcache (axi_arcache),
        .axi_arprot  (axi_arprot),
        .axi_arvalid (axi_arvalid),
        .axi_rid     (axi_rid),
        .axi_rresp   (axi_rresp),
        .axi_rvalid  (axi_rvalid),
        .axi_rdata   (axi_rdata),
        .axi_rlast   (axi_rlast),
        .axi_rready  (axi_rready),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_mem [0:MEM_DEPTH-1];

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected beat i of a burst, straight from the addressing rules.
    function automatic void model_beat(
        input  logic [31:0] addr,
        input  logic [7:0]  len,
        input  logic [2:0]  sz,
        input  logic [1:0]  bt,
        input  int          i,
        output logic [31:0] d,
        output logic [1:0]  resp
    );
        longint step;
        longint wb;
        longint base;
        longint a;
        longint idx;
        bit     all_err;
        step    = longint'(1) << sz;
        wb      = (longint'(len) + 1) * step;
        all_err = (sz > 3'd2) || (bt == 2'd3) ||
                  ((bt == 2'd2) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
        case (bt)
            2'd0: a = longint'(addr);
            2'd2: begin
                base = longint'(addr) - (longint'(addr) % wb);
                a    = base + ((longint'(addr) - base + i * step) % wb);
            end
            default: a = longint'(addr) + i * step;
        endcase
        idx = a / 4;
        if (all_err || idx >= MEM_DEPTH) begin
            d    = 32'd0;
            resp = 2'd2;
        end else begin
            d    = model_mem[int'(idx)];
            resp = 2'd0;
        end
    endfunction

    task automatic load_word(input int a, input logic [31:0] d);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = 10'(a);
        ld_data = d;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
        model_mem[a] = d;
    endtask

    // One full AR + R transaction. hold_beat/hold_cyc force rready low on
    // a chosen beat; rand_ready adds random back-pressure; ld_on fires a
    // backdoor write in the AR handshake cycle.
    task automatic run_txn(
        input logic [3:0]  id,
        input logic [31:0] addr,
        input logic [7:0]  len,
        input logic [2:0]  sz,
        input logic [1:0]  bt,
        input int          hold_beat,
        input int          hold_cyc,
        input bit          rand_ready,
        input bit          ld_on,
        input int          ld_a,
        input logic [31:0] ld_d
    );
        logic [31:0] exp_d [0:255];
        logic [1:0]  exp_r [0:255];
        int          beat;
        int          waited;
        int          holds_left;
        bit          first;
        for (int i = 0; i <= int'(len); i++) begin
            model_beat(addr, len, sz, bt, i, exp_d[i], exp_r[i]);
        end
        @(negedge clk);
        chk_val("arready_idle", axi_arready, 1);
        axi_arvalid = 1'b1;
        axi_arid    = id;
        axi_araddr  = addr;
        axi_arlen   = len;
        axi_arsize  = sz;
        axi_arburst = bt;
        if (ld_on) begin
            ld_en   = 1'b1;
            ld_addr = 10'(ld_a);
            ld_data = ld_d;
        end
        @(posedge clk);
        #1;
        axi_arvalid = 1'b0;
        ld_en       = 1'b0;
        if (ld_on) model_mem[ld_a] = ld_d;

        beat       = 0;
        waited     = 0;
        holds_left = hold_cyc;
        first      = 1'b1;
        while (beat <= int'(len) && waited < 200) begin
            @(negedge clk);
            if (beat == hold_beat && holds_left > 0) begin
                axi_rready = 1'b0;
                holds_left--;
            end else if (rand_ready && $urandom_range(0, 3) == 0) begin
                axi_rready = 1'b0;
            end else begin
                axi_rready = 1'b1;
            end
            if (first) begin
                chk_val("first_rvalid", axi_rvalid, 1);
                first = 1'b0;
            end
            chk_val("arready_busy", axi_arready, 0);
            if (axi_rvalid) begin
                chk_val($sformatf("rdata[%0d]", beat), axi_rdata, exp_d[beat]);
                chk_val($sformatf("rresp[%0d]", beat), axi_rresp, exp_r[beat]);
                chk_val($sformatf("rid[%0d]", beat), axi_rid, id);
                chk_val($sformatf("rlast[%0d]", beat), axi_rlast, (beat == int'(len)));
                if (axi_rready) beat++;
            end else begin
                waited++;
            end
        end
        chk_val("beat_count", beat, int'(len) + 1);
        @(negedge clk);
        axi_rready = 1'b1;
        chk_val("rvalid_after", axi_rvalid, 0);
        chk_val("arready_after", axi_arready, 1);
        $display("TXN id=%0h addr=%h len=%0d size=%0d burst=%0d beats=%0d checks=%0d",
                 id, addr, len, sz, bt, beat, checks);
    endtask

    initial begin
        int          seen;
        int          cyc;
        logic [3:0]  r_id;
        logic [31:0] r_addr;
        logic [7:0]  r_len;
        logic [2:0]  r_sz;
        logic [1:0]  r_bt;

        rst         = 1'b0;
        axi_arid    = '0;
        axi_araddr  = '0;
        axi_arlen   = '0;
        axi_arsize  = '0;
        axi_arburst = '0;
        axi_arlock  = 1'b0;
        axi_arcache = '0;
        axi_arprot  = '0;
        axi_arvalid = 1'b0;
        axi_rready  = 1'b1;
        ld_en       = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_val("rst_arready", axi_arready, 0);
        chk_val("rst_rvalid", axi_rvalid, 0);
        chk_val("rst_rlast", axi_rlast, 0);
        chk_val("rst_rid", axi_rid, 0);
        chk_val("rst_rresp", axi_rresp, 0);
        chk_val("rst_rdata", axi_rdata, 0);
        rst = 1'b1;
        @(negedge clk);
        chk_val("rel_arready", axi_arready, 1);

        for (int i = 0; i < MEM_DEPTH; i++) load_word(i, 32'(i));

        // INCR 16 beats from 0x100
        run_txn(4'h5, 32'h100, 8'd15, 3'd2, 2'd1, -1, 0, 1'b0, 1'b0, 0, 0);
        // WRAP 16 beats from 0x120
        run_txn(4'hA, 32'h120, 8'd15, 3'd2, 2'd2, -1, 0, 1'b0, 1'b0, 0, 0);
        // rready low 3 cycles on beat 5 (data 0x44)
        run_txn(4'h3, 32'h100, 8'd15, 3'd2, 2'd1, 4, 3, 1'b0, 1'b0, 0, 0);
        // INCR crossing the top of memory
        run_txn(4'h7, 32'hFFC, 8'd1, 3'd2, 2'd1, -1, 0, 1'b0, 1'b0, 0, 0);
        // FIXED, oversized beat, reserved burst, illegal WRAP length
        run_txn(4'h1, 32'h080, 8'd3, 3'd2, 2'd0, -1, 0, 1'b0, 1'b0, 0, 0);
        run_txn(4'h2, 32'h080, 8'd1, 3'd3, 2'd1, -1, 0, 1'b0, 1'b0, 0, 0);
        run_txn(4'h4, 32'h080, 8'd2, 3'd2, 2'd3, -1, 0, 1'b0, 1'b0, 0, 0);
        run_txn(4'h6, 32'h080, 8'd2, 3'd2, 2'd2, -1, 0, 1'b0, 1'b0, 0, 0);

        // Reset in the middle of a burst, at beat 7
        @(negedge clk);
        axi_arvalid = 1'b1;
        axi_arid    = 4'h9;
        axi_araddr  = 32'h100;
        axi_arlen   = 8'd15;
        axi_arsize  = 3'd2;
        axi_arburst = 2'd1;
        @(posedge clk);
        #1;
        axi_arvalid = 1'b0;
        seen = 0;
        cyc  = 0;
        while (seen < 6 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (axi_rvalid) seen++;
        end
        @(negedge clk);
        chk_val("mid_rvalid", axi_rvalid, 1);
        chk_val("mid_rdata", axi_rdata, 32'h46);
        rst = 1'b0;
        @(negedge clk);
        chk_val("abort_rvalid", axi_rvalid, 0);
        chk_val("abort_arready", axi_arready, 0);
        rst = 1'b1;
        @(negedge clk);
        chk_val("abort_rel_arready", axi_arready, 1);
        chk_val("abort_rel_rvalid", axi_rvalid, 0);
        run_txn(4'hB, 32'h100, 8'd7, 3'd2, 2'd1, -1, 0, 1'b0, 1'b0, 0, 0);

        // Backdoor write of word 0x41 during its read, then reread
        run_txn(4'hC, 32'h104, 8'd0, 3'd2, 2'd1, -1, 0, 1'b0, 1'b1, 32'h41, 32'hDEAD);
        run_txn(4'hC, 32'h104, 8'd0, 3'd2, 2'd1, -1, 0, 1'b0, 1'b0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 64; i++) load_word(int'($urandom_range(0, MEM_DEPTH - 1)), $urandom);
        for (int t = 0; t < 40; t++) begin
            r_id   = 4'($urandom_range(0, 15));
            r_bt   = 2'($urandom_range(0, 3));
            r_sz   = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            r_addr = 32'($urandom_range(0, 32'h1100));
            if ($urandom_range(0, 1) == 1) r_addr = r_addr & ~((32'd1 << r_sz) - 32'd1);
            r_len  = 8'($urandom_range(0, 20));
            if (r_bt == 2'd2 && $urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 3))
                    0: r_len = 8'd1;
                    1: r_len = 8'd3;
                    2: r_len = 8'd7;
                    default: r_len = 8'd15;
                endcase
            end
            run_txn(r_id, r_addr, r_len, r_sz, r_bt, -1, 0, 1'b1, 1'b0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
